// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the pipeline memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int          WORD_W            = 32;
    localparam int          CNT_W             = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : DEPTH x 32 word array, synchronous write, asynchronous read.
//               Takes a word index only; range checking lives in the caller.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory
    import mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Write port: commits on the rising edge when enabled; contents are never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory stage. Performs word loads/stores with a
//               configurable multi-cycle latency, stalls upstream via ready,
//               and drives the registered MEM/WB outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_Res,
    input  logic [31:0] Val_Rm,
    input  logic [3:0]  Dest,
    output logic        ready,
    output logic        WB_EN_out,
    output logic        MEM_R_EN_out,
    output logic [31:0] ALU_Res_out,
    output logic [31:0] Mem_Data,
    output logic [3:0]  Dest_out,
    output logic        addr_err
);

    localparam int AW = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             mem_req;
    logic [31:0]      offset;
    logic [AW-1:0]    word_idx;
    logic             bad_addr;
    logic             mem_we;
    logic [31:0]      rdata;

    assign mem_req  = MEM_R_EN | MEM_W_EN;
    assign offset   = ALU_Res - BASE_ADDR;
    assign word_idx = offset[AW+1:2];

    // Below base, misaligned, or beyond the array. With a word-aligned base the
    // two alignment terms agree; both are kept so an odd base is still caught.
    assign bad_addr = (ALU_Res < BASE_ADDR)
                   || (ALU_Res[1:0] != 2'b00)
                   || (offset[1:0] != 2'b00)
                   || (offset[31:AW+2] != '0);

    // Stores only land in DONE so an aborted access never touches memory.
    assign mem_we = (state_q == DONE) && MEM_W_EN && !bad_addr;

    data_memory #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_memory (
        .clk     (clk),
        .we_i    (mem_we),
        .idx_i   (word_idx),
        .wdata_i (Val_Rm),
        .rdata_o (rdata)
    );

    // FSM state and latency counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and ready: ready stays low from request until DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b1;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    ready   = 1'b0;
                end
            end
            ACCESS: begin
                ready = 1'b0;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // MEM/WB register: bubble on stall edges, mem result in DONE, else pass-through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            ALU_Res_out  <= '0;
            Mem_Data     <= '0;
            Dest_out     <= '0;
            addr_err     <= 1'b0;
        end else if (!ready) begin
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
        end else if (state_q == DONE) begin
            WB_EN_out    <= WB_EN;
            MEM_R_EN_out <= MEM_R_EN;
            ALU_Res_out  <= ALU_Res;
            Mem_Data     <= (MEM_R_EN && !MEM_W_EN && !bad_addr) ? rdata : 32'd0;
            Dest_out     <= Dest;
            addr_err     <= bad_addr;
        end else begin
            WB_EN_out    <= WB_EN;
            MEM_R_EN_out <= MEM_R_EN;
            ALU_Res_out  <= ALU_Res;
            Dest_out     <= Dest;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage (WAIT_CYCLES=3 main instance,
//               WAIT_CYCLES=0 instance for the minimum-latency case).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        WB_EN = 1'b0, MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
    logic [31:0] ALU_Res = '0, Val_Rm = '0;
    logic [3:0]  Dest = '0;
    logic        ready, WB_EN_out, MEM_R_EN_out, addr_err;
    logic [31:0] ALU_Res_out, Mem_Data;
    logic [3:0]  Dest_out;

    logic        z_wb = 1'b0, z_re = 1'b0, z_we = 1'b0;
    logic [31:0] z_addr = '0, z_val = '0;
    logic [3:0]  z_dest = '0;
    logic        z_ready, z_wb_out, z_re_out, z_err;
    logic [31:0] z_alu_out, z_mem_data;
    logic [3:0]  z_dest_out;

    typedef struct {
        logic        wb;
        logic        mre;
        logic [31:0] alu;
        logic [31:0] data;
        logic        chk_data;
        logic [3:0]  dest;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;

    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_active = 1'b0;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(3)) u_dut (
        .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest), .ready(ready),
        .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .ALU_Res_out(ALU_Res_out),
        .Mem_Data(Mem_Data), .Dest_out(Dest_out), .addr_err(addr_err)
    );

    mem_stage #(.DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .WB_EN(z_wb), .MEM_R_EN(z_re), .MEM_W_EN(z_we),
        .ALU_Res(z_addr), .Val_Rm(z_val), .Dest(z_dest), .ready(z_ready),
        .WB_EN_out(z_wb_out), .MEM_R_EN_out(z_re_out), .ALU_Res_out(z_alu_out),
        .Mem_Data(z_mem_data), .Dest_out(z_dest_out), .addr_err(z_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one instruction, count ready-low cycles, push the expected result at DONE.
    task automatic mem_op(input logic wb, input logic re, input logic we,
                          input logic [31:0] addr, input logic [31:0] val, input logic [3:0] dst,
                          input int exp_low, input logic exp_err,
                          input logic [31:0] exp_data, input logic chk_data);
        exp_t e;
        int   low  = 0;
        bit   seen = 0;
        @(posedge clk); #1;
        WB_EN = wb; MEM_R_EN = re; MEM_W_EN = we; ALU_Res = addr; Val_Rm = val; Dest = dst;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                seen = 1;
                break;
            end
            low++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready never returned high for addr %h", addr);
        end else begin
            chk("ready_low_cycles", low, exp_low);
            e.wb = wb; e.mre = re; e.alu = addr; e.data = exp_data;
            e.chk_data = chk_data; e.dest = dst; e.err = exp_err;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0; ALU_Res = '0; Val_Rm = '0; Dest = '0;
    endtask

    // Monitor: after an edge that followed a ready cycle with an instruction, compare
    // MEM/WB against the scoreboard; after a stall edge, require a bubble.
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid) begin
                if (prev_ready && prev_active) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: output committed with empty scoreboard, ALU_Res_out=%h", ALU_Res_out);
                    end else begin
                        m_e = sb.pop_front();
                        chk("WB_EN_out", {31'd0, WB_EN_out}, {31'd0, m_e.wb});
                        chk("MEM_R_EN_out", {31'd0, MEM_R_EN_out}, {31'd0, m_e.mre});
                        chk("ALU_Res_out", ALU_Res_out, m_e.alu);
                        chk("Dest_out", {28'd0, Dest_out}, {28'd0, m_e.dest});
                        chk("addr_err", {31'd0, addr_err}, {31'd0, m_e.err});
                        if (m_e.chk_data) chk("Mem_Data", Mem_Data, m_e.data);
                    end
                end else if (!prev_ready) begin
                    chk("bubble_WB_EN_out", {31'd0, WB_EN_out}, 32'd0);
                    chk("bubble_MEM_R_EN_out", {31'd0, MEM_R_EN_out}, 32'd0);
                end
            end
            prev_ready  = ready;
            prev_active = WB_EN | MEM_R_EN | MEM_W_EN;
            prev_valid  = 1'b1;
        end
    end

    initial begin
        int low;
        // Reset state
        #2;
        chk("rst_WB_EN_out", {31'd0, WB_EN_out}, 32'd0);
        chk("rst_MEM_R_EN_out", {31'd0, MEM_R_EN_out}, 32'd0);
        chk("rst_ALU_Res_out", ALU_Res_out, 32'd0);
        chk("rst_Mem_Data", Mem_Data, 32'd0);
        chk("rst_Dest_out", {28'd0, Dest_out}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        @(negedge clk); @(negedge clk); #1;
        rst = 1'b1;

        //     wb re we addr       val            dst low err data           chk
        mem_op(1, 0, 0, 32'd5,     32'd0,         3,  0,  0,  32'd0,         0);
        mem_op(0, 0, 1, 32'd1028,  32'hDEADBEEF,  0,  5,  0,  32'd0,         0);
        mem_op(1, 1, 0, 32'd1028,  32'd0,         7,  5,  0,  32'hDEADBEEF,  1);
        mem_op(0, 0, 1, 32'd1024,  32'h55AA55AA,  0,  5,  0,  32'd0,         0);
        mem_op(1, 1, 0, 32'd1020,  32'd0,         1,  5,  1,  32'd0,         1);
        mem_op(1, 0, 0, 32'd9,     32'd0,         2,  0,  1,  32'd0,         0);
        mem_op(1, 1, 0, 32'd1026,  32'd0,         1,  5,  1,  32'd0,         1);
        mem_op(1, 1, 0, 32'd1280,  32'd0,         1,  5,  1,  32'd0,         1);
        mem_op(0, 0, 1, 32'd1020,  32'h0BADF00D,  0,  5,  1,  32'd0,         0);
        mem_op(1, 1, 0, 32'd1024,  32'd0,         8,  5,  0,  32'h55AA55AA,  1);
        mem_op(1, 1, 1, 32'd1040,  32'h00001234,  4,  5,  0,  32'd0,         1);
        mem_op(1, 1, 0, 32'd1040,  32'd0,         9,  5,  0,  32'h00001234,  1);
        mem_op(1, 0, 1, 32'd1032,  32'h11111111,  5,  5,  0,  32'd0,         0);
        idle();

        // Zero-wait instance: ready low exactly two cycles per op
        @(posedge clk); #1;
        z_we = 1; z_addr = 32'd1036; z_val = 32'h0A0B0C0D;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (z_ready) break;
            low++;
        end
        chk("w0_store_low", low, 2);
        @(posedge clk); #1;
        z_we = 0; z_re = 1; z_dest = 4'd6;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (z_ready) break;
            low++;
        end
        chk("w0_load_low", low, 2);
        @(posedge clk); #1;
        chk("w0_Mem_Data", z_mem_data, 32'h0A0B0C0D);
        chk("w0_MEM_R_EN_out", {31'd0, z_re_out}, 32'd1);
        z_re = 0; z_addr = '0; z_val = '0; z_dest = '0;

        // Reset pulse in the middle of a store to 1032
        @(posedge clk); #1;
        MEM_W_EN = 1; ALU_Res = 32'd1032; Val_Rm = 32'hCAFEF00D; Dest = 4'd5; WB_EN = 1;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("abort_ALU_Res_out", ALU_Res_out, 32'd0);
        chk("abort_Dest_out", {28'd0, Dest_out}, 32'd0);
        chk("abort_WB_EN_out", {31'd0, WB_EN_out}, 32'd0);
        chk("abort_addr_err", {31'd0, addr_err}, 32'd0);
        chk("abort_ready_req", {31'd0, ready}, 32'd0);
        MEM_W_EN = 0; WB_EN = 0; ALU_Res = '0; Val_Rm = '0; Dest = '0;
        #1;
        chk("abort_ready_noreq", {31'd0, ready}, 32'd1);
        @(negedge clk); @(posedge clk); @(negedge clk); #1;
        rst = 1'b1;

        mem_op(1, 1, 0, 32'd1032,  32'd0,         6,  5,  0,  32'h11111111,  1);
        idle();
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always reaches its summary line.
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
